// File: rtl/aes_pad_xor_if.sv
// rtl/aes_pad_xor_if.sv - handshake bundle between aes_pad_xor, the pad generator and the data path
interface aes_pad_xor_if #(
    parameter int W          = 4,
    parameter int AESWidth   = 128,
    parameter int AESEntropy = 64
);
    logic [AESEntropy-1:0]   IVIn;
    logic                    IVInValid;
    logic                    IVInReady;
    logic [AESEntropy-1:0]   AESSeed;
    logic                    AESSeedValid;
    logic                    AESSeedReady;
    logic [W*AESWidth-1:0]   AESPad;
    logic                    AESPadValid;
    logic [W*AESWidth-1:0]   DataIn;
    logic                    DataInValid;
    logic                    DataInReady;
    logic [W*AESWidth-1:0]   DataOut;
    logic                    DataOutValid;
    logic                    DataOutReady;

    modport slave (
        input  IVIn, IVInValid, AESSeedReady, AESPad, AESPadValid,
        input  DataIn, DataInValid, DataOutReady,
        output IVInReady, AESSeed, AESSeedValid, DataInReady, DataOut, DataOutValid
    );

    modport master (
        output IVIn, IVInValid, AESSeedReady, AESPad, AESPadValid,
        output DataIn, DataInValid, DataOutReady,
        input  IVInReady, AESSeed, AESSeedValid, DataInReady, DataOut, DataOutValid
    );
endinterface

// File: rtl/aes_pad_xor.sv
// rtl/aes_pad_xor.sv - issues per-IV counter seeds, buffers returned pads, XORs them onto the chunk stream
module aes_pad_xor #(
    parameter int W              = 4,
    parameter int AESWidth       = 128,
    parameter int AESEntropy     = 64,
    parameter int AESLatency     = 21,
    parameter int ChunksPerBlock = 8,
    parameter int PadDepth       = 32
) (
    input logic          Clock,
    input logic          Reset,
    aes_pad_xor_if.slave bus
);
    localparam int ChunkW = W * AESWidth;
    localparam int IdxW   = (ChunksPerBlock > 1) ? $clog2(ChunksPerBlock) : 1;
    localparam int CntW   = $clog2(PadDepth + 1);
    localparam int PtrW   = $clog2(PadDepth);

    typedef enum logic {IDLE, ISSUE} fsmState;

    fsmState               state, stateNext;
    logic [AESEntropy-1:0] ivReg;
    logic [IdxW-1:0]       chunkIdx;
    logic [CntW-1:0]       inFlight, fifoCount;
    logic [PtrW-1:0]       wrPtr, rdPtr;
    logic [ChunkW-1:0]     padMem [PadDepth];
    logic [ChunkW-1:0]     dataOut;
    logic                  dataOutValid;
    logic [AESLatency-1:0] seedHist;

    logic          ivReady, seedValid, ivFire, seedFire, dataFire, padPush;
    logic          fifoFull, fifoEmpty, lastChunk;
    logic [CntW:0] credit;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(PadDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Seeds in flight plus stored pads never exceed PadDepth, so every returning pad has a slot.
    assign credit    = {1'b0, inFlight} + {1'b0, fifoCount};
    assign fifoFull  = (fifoCount == CntW'(PadDepth));
    assign fifoEmpty = (fifoCount == '0);
    assign lastChunk = (chunkIdx == IdxW'(ChunksPerBlock - 1));

    always_comb begin
        stateNext = state;
        ivReady   = 1'b0;
        seedValid = 1'b0;
        case (state)
            IDLE: begin
                ivReady = !Reset;
                if (ivReady && bus.IVInValid) stateNext = ISSUE;
            end
            ISSUE: begin
                seedValid = !Reset && (credit < (CntW + 1)'(PadDepth));
                if (seedValid && bus.AESSeedReady && lastChunk) stateNext = IDLE;
            end
        endcase
    end

    assign ivFire   = ivReady & bus.IVInValid;
    assign seedFire = seedValid & bus.AESSeedReady;
    assign dataFire = bus.DataInValid & bus.DataInReady;
    assign padPush  = bus.AESPadValid && (!fifoFull || dataFire);

    assign bus.IVInReady    = ivReady;
    assign bus.AESSeedValid = seedValid;
    assign bus.AESSeed      = ivReg + AESEntropy'(chunkIdx) * AESEntropy'(W);
    assign bus.DataInReady  = !Reset && !fifoEmpty && (!dataOutValid || bus.DataOutReady);
    assign bus.DataOut      = dataOut;
    assign bus.DataOutValid = dataOutValid;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ivReg    <= '0;
            chunkIdx <= '0;
        end else if (ivFire) begin
            ivReg    <= bus.IVIn;
            chunkIdx <= '0;
        end else if (seedFire) begin
            chunkIdx <= lastChunk ? '0 : chunkIdx + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            inFlight  <= '0;
            fifoCount <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
        end else begin
            case ({seedFire, bus.AESPadValid})
                2'b10:   inFlight <= inFlight + 1'b1;
                2'b01:   inFlight <= inFlight - 1'b1;
                default: inFlight <= inFlight;
            endcase
            case ({padPush, dataFire})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
            if (padPush)  wrPtr <= nextPtr(wrPtr);
            if (dataFire) rdPtr <= nextPtr(rdPtr);
        end
    end

    always_ff @(posedge Clock) begin
        if (padPush) padMem[wrPtr] <= bus.AESPad;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            dataOut      <= '0;
            dataOutValid <= 1'b0;
        end else if (dataFire) begin
            dataOut      <= bus.DataIn ^ padMem[rdPtr];
            dataOutValid <= 1'b1;
        end else if (bus.DataOutReady) begin
            dataOutValid <= 1'b0;
        end
    end

    // Seed handshakes aged by the generator latency; a pad must line up with one.
    always_ff @(posedge Clock) begin
        if (Reset) seedHist <= '0;
        else       seedHist <= (seedHist << 1) | AESLatency'(seedFire);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            padOverflow: assert (!(bus.AESPadValid && fifoFull && !dataFire));
            padUnexpected: assert (!bus.AESPadValid || seedHist[AESLatency-1]);
        end
    end
endmodule
